// File: rtl/ud_dir_ctrl.sv
// Direction controller for the 4-bit up/down counter: synchronises and debounces
// a push-button (each clean press toggles U_D) and optionally ping-pongs at the bounds.
module ud_dir_ctrl #(
  parameter int Max       = 15,
  parameter int Min       = 0,
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       pp_en,
  input  logic [3:0] cnt,
  output logic       U_D,
  output logic       press
);

  localparam int              CW          = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0]   DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [3:0]      CNT_MAX     = 4'(Max);
  localparam logic [3:0]      CNT_MAX_M1  = 4'(Max - 1);
  localparam logic [3:0]      CNT_MIN     = 4'(Min);
  localparam logic [3:0]      CNT_MIN_P1  = 4'(Min + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [1:0]    fill_q, fill_d;
  logic          btn_db_q, btn_db_d;
  logic          btn_db_d1_q, btn_db_d1_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic          ud_q, ud_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    s1_d        = btn;
    s2_d        = s1_q;
    fill_d      = {fill_q[0], 1'b1};
    btn_db_d    = btn_db_q;
    db_cnt_d    = '0;
    btn_db_d1_d = btn_db_q;

    if (s2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end

    // Presses are ignored until the button has been seen released once the
    // synchroniser holds real samples, so a button held through reset never fires.
    armed_d = armed_q | (fill_q[1] & ~s2_q & ~btn_db_q);
    press_d = armed_q & btn_db_q & ~btn_db_d1_q;

    ud_d = ud_q;
    if (press_q) begin
      ud_d = ~ud_q;
    end else if (pp_en) begin
      if      (!ud_q && cnt == CNT_MAX_M1) ud_d = 1'b1;
      else if ( ud_q && cnt == CNT_MIN_P1) ud_d = 1'b0;
      else if (!ud_q && cnt == CNT_MAX)    ud_d = 1'b1;
      else if ( ud_q && cnt == CNT_MIN)    ud_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      fill_q      <= 2'b00;
      btn_db_q    <= 1'b0;
      btn_db_d1_q <= 1'b0;
      db_cnt_q    <= '0;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
      ud_q        <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      fill_q      <= fill_d;
      btn_db_q    <= btn_db_d;
      btn_db_d1_q <= btn_db_d1_d;
      db_cnt_q    <= db_cnt_d;
      armed_q     <= armed_d;
      press_q     <= press_d;
      ud_q        <= ud_d;
    end
  end

  assign U_D   = ud_q;
  assign press = press_q;

endmodule

// File: tb/tb_ud_dir_ctrl.sv
// Self-checking bench for ud_dir_ctrl with DB_CYCLES=4, Max=15, Min=0 and a
// behavioural up/down counter closing the cnt/U_D loop when selected.
module tb_ud_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       pp_en = 1'b0;
  logic [3:0] cnt_vec = 4'd0;
  logic       use_ctr = 1'b0;
  logic [3:0] cnt_drv;
  logic       U_D;
  logic       press;

  logic [3:0] ctr_q;
  logic       ud_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       pp_en;
    logic [3:0] cnt;
    logic       exp_ud;
    logic       exp_press;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  ud_dir_ctrl #(.Max(15), .Min(0), .DB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .pp_en (pp_en),
    .cnt   (cnt_drv),
    .U_D   (U_D),
    .press (press)
  );

  // Downstream counter: latches U_D on negedge, counts on posedge, wraps freely.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) ud_s <= 1'b0;
    else        ud_s <= U_D;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ctr_q <= 4'd0;
    else if (ud_s) ctr_q <= ctr_q - 4'd1;
    else           ctr_q <= ctr_q + 4'd1;
  end

  assign cnt_drv = use_ctr ? ctr_q : cnt_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset U_D", U_D, 0);
    check("reset press", press, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts press pulses over a window; exp_idx = cycle of the single expected pulse, 0 = none.
  task automatic press_window(input string name, input int cycles, input int exp_idx);
    int n = 0;
    int first = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk); #1;
      if (press === 1'b1) begin
        n++;
        if (first == 0) first = i;
      end
    end
    check({name, " pulse count"}, n, (exp_idx != 0) ? 1 : 0);
    if (exp_idx != 0) check({name, " latency"}, first, exp_idx);
  endtask

  function automatic int tri_wave(input int k);
    int m = k % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bounce[16];
    int   nb;

    vecs[0]  = '{1'b0, 4'd14, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd15, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd13, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd14, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'd14, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'd5,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'd1,  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd1,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd0,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd15, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd15, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'd0,  1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'd15, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'd1,  1'b0, 1'b0};

    // Auto-reverse rule table, one clock per vector, starting from U_D=0.
    do_reset();
    foreach (vecs[i]) begin
      pp_en   = vecs[i].pp_en;
      cnt_vec = vecs[i].cnt;
      @(posedge clk); #1;
      check($sformatf("vec%0d U_D", i), U_D, vecs[i].exp_ud);
      check($sformatf("vec%0d press", i), press, vecs[i].exp_press);
    end

    // 1: reset with btn low, counter counts up.
    pp_en   = 1'b0;
    use_ctr = 1'b1;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("t1 cnt step%0d", k), ctr_q, k);
      check($sformatf("t1 U_D step%0d", k), U_D, 0);
    end

    // 2: clean press -> one pulse 7 cycles after rise, U_D 0->1; release gives no pulse.
    use_ctr = 1'b0;
    cnt_vec = 4'd7;
    @(posedge clk); #1;
    btn = 1'b1;
    press_window("t2 press", 20, 7);
    check("t2 U_D after press", U_D, 1);
    btn = 1'b0;
    press_window("t2 release", 10, 0);

    // 3: bounces of 1-3 cycles are rejected.
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    nb = 0;
    foreach (bounce[i]) begin
      btn = bounce[i];
      @(posedge clk); #1;
      if (press === 1'b1) nb++;
    end
    btn = 1'b0;
    check("t3 bounce pulses", nb, 0);
    press_window("t3 settle", 10, 0);
    check("t3 U_D held", U_D, 1);

    // 4: ping-pong with the counter in the loop.
    use_ctr = 1'b1;
    pp_en   = 1'b1;
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      check($sformatf("t4 cnt k%0d", k), ctr_q, tri_wave(k));
      if (tri_wave(k) == 15) check($sformatf("t4 U_D at max k%0d", k), U_D, 1);
      if (tri_wave(k) == 0)  check($sformatf("t4 U_D at min k%0d", k), U_D, 0);
    end

    // 5: accepted press coincides with cnt==Max-1 while counting up: single flip.
    use_ctr = 1'b0;
    cnt_vec = 4'd10;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    btn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("t5 press present", press, 1);
    check("t5 U_D before", U_D, 0);
    cnt_vec = 4'd14;
    @(posedge clk); #1;
    check("t5 U_D after toggle", U_D, 1);
    check("t5 press dropped", press, 0);
    cnt_vec = 4'd15;
    @(posedge clk); #1;
    check("t5 U_D at max", U_D, 1);
    cnt_vec = 4'd14;
    @(posedge clk); #1;
    check("t5 U_D no double flip", U_D, 1);
    pp_en = 1'b0;
    btn   = 1'b0;
    press_window("t5 release", 10, 0);

    // 6: reset while btn held mid-debounce (db_cnt=2).
    btn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6 U_D in reset", U_D, 0);
    check("t6 press in reset", press, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    press_window("t6 held after reset", 20, 0);
    check("t6 U_D held", U_D, 0);
    btn = 1'b0;
    press_window("t6 release", 10, 0);
    btn = 1'b1;
    press_window("t6 re-press", 20, 7);
    check("t6 U_D toggled", U_D, 1);
    btn = 1'b0;
    press_window("t6 release2", 10, 0);

    // 6b: reset mid-pulse clears press at once; no pulse with btn still held afterwards.
    btn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("t6b pulse before reset", press, 1);
    rst_n = 1'b0;
    #1;
    check("t6b press cleared", press, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    press_window("t6b held after reset", 15, 0);
    btn = 1'b0;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
